// File: rtl/pwm_ctrl_pkg.sv
// Shared types, constants and duty-step helpers for the PWM soft-start controller.
package pwm_ctrl_pkg;
  localparam int DUTY_W      = 8;
  localparam int NCH_DEFAULT = 16;

  typedef enum logic [1:0] {OFF, RAMP, ON, RAMP_DOWN} ctrl_state_t;

  // A programmed step of 0 behaves as 1, so a ramp can never stall.
  function automatic logic [DUTY_W:0] eff_step(input logic [DUTY_W-1:0] raw);
    return (raw == '0) ? (DUTY_W+1)'(1) : {1'b0, raw};
  endfunction

  // Move cur toward tgt by s. The arithmetic is 9 bits wide, so the
  // result clamps at tgt instead of overshooting or wrapping.
  function automatic logic [DUTY_W-1:0] step_sat(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt,
                                                 input logic [DUTY_W:0]   s);
    logic [DUTY_W:0]   sum;
    logic [DUTY_W:0]   gap;
    logic [DUTY_W-1:0] res;
    sum = {1'b0, cur} + s;
    gap = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt) res = (sum > {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
    else           res = (s >= gap) ? tgt : (cur - s[DUTY_W-1:0]);
    return res;
  endfunction
endpackage

// File: rtl/pwm_soft_start_ctrl_tick.sv
// Ramp prescaler: while run is high, fires tick once every div+1 cycles.
module ramp_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  // Uses >= rather than ==. If div is lowered below the current count,
  // the tick fires at once instead of waiting for the counter to wrap.
  assign tick = run && (cnt >= div);

  // The count restarts on a tick, on state entry, or while idle. It never
  // passes div, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (clear || !run || tick) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pwm_soft_start_ctrl.sv
// Ramps the PWM duty toward the target in timed steps and gates channel
// enables. Provides soft-start on master_en rise and soft-stop on fall.
module pwm_soft_start_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int STEP_W = 4,
  parameter int NCH    = NCH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              master_en,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [DIV_W-1:0]  ramp_div,
  input  logic [STEP_W-1:0] ramp_step,
  input  logic [NCH-1:0]    en_pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [NCH-1:0]    en_pwm_out,
  output logic              busy,
  output logic              done
);
  ctrl_state_t       state_q, state_n;
  logic [DUTY_W-1:0] duty_q, duty_n;
  logic              gate_q, gate_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [DUTY_W:0]   s;
  logic              run, clear, tick;

  assign s     = eff_step(DUTY_W'(ramp_step));
  assign run   = (state_q == RAMP) || (state_q == RAMP_DOWN);
  assign clear = (state_n != state_q) && ((state_n == RAMP) || (state_n == RAMP_DOWN));

  ramp_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clear),
    .div   (ramp_div),
    .tick  (tick)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      duty_q  <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      duty_q  <= duty_n;
      gate_q  <= gate_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state and datapath. Dropping master_en takes priority over a
  // completion or retarget in the same cycle.
  always_comb begin
    state_n = state_q;
    duty_n  = duty_q;
    gate_n  = gate_q;
    done_n  = 1'b0;
    unique case (state_q)
      OFF: begin
        duty_n = '0;
        gate_n = 1'b0;
        if (master_en) begin
          state_n = RAMP;
          gate_n  = 1'b1;
        end
      end
      RAMP: begin
        if (!master_en) state_n = RAMP_DOWN;
        else if (tick) begin
          duty_n = step_sat(duty_q, target_duty, s);
          if (duty_n == target_duty) begin
            state_n = ON;
            done_n  = 1'b1;
          end
        end
      end
      ON: begin
        if (!master_en)                 state_n = RAMP_DOWN;
        else if (target_duty != duty_q) state_n = RAMP;
      end
      RAMP_DOWN: begin
        // Re-enabling resumes from the current duty, so the gate never drops.
        if (master_en) state_n = RAMP;
        else if (tick) begin
          duty_n = step_sat(duty_q, '0, s);
          if (duty_n == '0) begin
            state_n = OFF;
            gate_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = OFF;
    endcase
    busy_n = (state_n == RAMP) || (state_n == RAMP_DOWN);
  end

  assign duty_out   = duty_q;
  assign en_pwm_out = en_pwm_in & {NCH{gate_q}};
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_pwm_soft_start_ctrl.sv
// Bench for pwm_soft_start_ctrl. Each test-plan scenario is a row of
// expected values, and a behavioural model is compared on every cycle.
module tb_pwm_soft_start_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        master_en = 1'b0;
  logic [7:0]  target_duty = 8'h00;
  logic [15:0] ramp_div = 16'd0;
  logic [4:0]  ramp_step = 5'd0;
  logic [15:0] en_pwm_in = 16'h0000;
  logic [7:0]  duty_out;
  logic [15:0] en_pwm_out;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_soft_start_ctrl #(.DIV_W(16), .STEP_W(5), .NCH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .master_en   (master_en),
    .target_duty (target_duty),
    .ramp_div    (ramp_div),
    .ramp_step   (ramp_step),
    .en_pwm_in   (en_pwm_in),
    .duty_out    (duty_out),
    .en_pwm_out  (en_pwm_out),
    .busy        (busy),
    .done        (done)
  );

  // Reference model. Phases are tracked as flags (gate on, moving,
  // stopping), and the time since the last tick is an elapsed-cycle count.
  int m_duty, m_elapsed;
  bit m_gate, m_moving, m_stop, m_done;

  function automatic void model_reset();
    m_duty = 0; m_elapsed = 0; m_gate = 0; m_moving = 0; m_stop = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    int s;
    bit tk;
    s  = (ramp_step == 0) ? 1 : int'(ramp_step);
    tk = m_moving && (m_elapsed >= int'(ramp_div));
    m_done = 0;
    if (!m_gate) begin
      m_duty = 0;
      if (master_en) begin m_gate = 1; m_moving = 1; m_stop = 0; m_elapsed = 0; end
    end else if (!m_moving) begin
      if (!master_en) begin m_moving = 1; m_stop = 1; m_elapsed = 0; end
      else if (int'(target_duty) != m_duty) begin m_moving = 1; m_stop = 0; m_elapsed = 0; end
    end else if (!m_stop) begin
      if (!master_en) begin m_stop = 1; m_elapsed = 0; end
      else if (tk) begin
        if (m_duty < int'(target_duty)) m_duty = (m_duty + s > int'(target_duty)) ? int'(target_duty) : m_duty + s;
        else                            m_duty = (m_duty - s < int'(target_duty)) ? int'(target_duty) : m_duty - s;
        m_elapsed = 0;
        if (m_duty == int'(target_duty)) begin m_moving = 0; m_done = 1; end
      end else m_elapsed++;
    end else begin
      if (master_en) begin m_stop = 0; m_elapsed = 0; end
      else if (tk) begin
        m_duty = (m_duty - s < 0) ? 0 : m_duty - s;
        m_elapsed = 0;
        if (m_duty == 0) begin m_gate = 0; m_moving = 0; m_stop = 0; m_done = 1; end
      end else m_elapsed++;
    end
  endfunction

  task automatic check(input string nm, input logic [7:0] ed, input logic [15:0] ee,
                       input logic eb, input logic edn);
    n_tests++;
    if (duty_out !== ed || en_pwm_out !== ee || busy !== eb || done !== edn) begin
      n_fail++;
      $display("FAIL %s: got duty=%h en=%h busy=%b done=%b, want duty=%h en=%h busy=%b done=%b",
               nm, duty_out, en_pwm_out, busy, done, ed, ee, eb, edn);
    end
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic step_cycle(input string nm);
    @(posedge clk);
    model_step();
    #1;
    check(nm, 8'(m_duty), m_gate ? en_pwm_in : 16'h0, m_moving, m_done);
  endtask

  typedef struct {
    bit          men;
    logic [7:0]  tgt;
    logic [15:0] div;
    logic [4:0]  step;
    logic [15:0] en;
    int          n;
    logic [7:0]  duty;
    logic [15:0] eo;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vt[$];

  initial begin
    // soft-start to 0x80 (div 3, step 16)
    vt.push_back('{1, 8'h80, 16'd3, 5'd16, 16'hFFFF,  1, 8'h00, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h80, 16'd3, 5'd16, 16'hFFFF,  4, 8'h10, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h80, 16'd3, 5'd16, 16'hFFFF, 28, 8'h80, 16'hFFFF, 1'b0, 1'b1});
    vt.push_back('{1, 8'h80, 16'd3, 5'd16, 16'hFFFF,  1, 8'h80, 16'hFFFF, 1'b0, 1'b0});
    // retarget down to 0x30
    vt.push_back('{1, 8'h30, 16'd0, 5'd16, 16'hFFFF,  6, 8'h30, 16'hFFFF, 1'b0, 1'b1});
    vt.push_back('{1, 8'h30, 16'd0, 5'd16, 16'hFFFF,  1, 8'h30, 16'hFFFF, 1'b0, 1'b0});
    // soft-stop (div 1, step 8)
    vt.push_back('{0, 8'h30, 16'd1, 5'd8,  16'hFFFF,  3, 8'h28, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{0, 8'h30, 16'd1, 5'd8,  16'hFFFF, 10, 8'h00, 16'h0000, 1'b0, 1'b1});
    vt.push_back('{0, 8'h30, 16'd1, 5'd8,  16'hFFFF,  1, 8'h00, 16'h0000, 1'b0, 1'b0});
    // saturating approach to 0x0A
    vt.push_back('{1, 8'h0A, 16'd0, 5'd4,  16'hFFFF,  2, 8'h04, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h0A, 16'd0, 5'd4,  16'hFFFF,  1, 8'h08, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h0A, 16'd0, 5'd4,  16'hFFFF,  1, 8'h0A, 16'hFFFF, 1'b0, 1'b1});
    // climb to 0x30, stop down to 0x18, re-enable mid-stop
    vt.push_back('{1, 8'h30, 16'd1, 5'd8,  16'hFFFF, 11, 8'h30, 16'hFFFF, 1'b0, 1'b1});
    vt.push_back('{0, 8'h30, 16'd1, 5'd8,  16'hFFFF,  7, 8'h18, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h30, 16'd1, 5'd8,  16'hFFFF,  1, 8'h18, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h30, 16'd1, 5'd8,  16'hFFFF,  2, 8'h20, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h30, 16'd1, 5'd8,  16'hFFFF,  2, 8'h28, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h30, 16'd1, 5'd8,  16'hFFFF,  2, 8'h30, 16'hFFFF, 1'b0, 1'b1});
    // retarget to 0x20 at 0x40 with a zero step
    vt.push_back('{1, 8'h80, 16'd0, 5'd16, 16'hFFFF,  2, 8'h40, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h20, 16'd0, 5'd0,  16'hFFFF,  1, 8'h3F, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{1, 8'h20, 16'd0, 5'd0,  16'hFFFF, 31, 8'h20, 16'hFFFF, 1'b0, 1'b1});
    // partial channel enables pass through the gate
    vt.push_back('{1, 8'h20, 16'd0, 5'd0,  16'h00F0,  1, 8'h20, 16'h00F0, 1'b0, 1'b0});
  end

  initial begin
    model_reset();
    #12;
    check("reset", 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < vt.size(); i++) begin
      master_en   = vt[i].men;
      target_duty = vt[i].tgt;
      ramp_div    = vt[i].div;
      ramp_step   = vt[i].step;
      en_pwm_in   = vt[i].en;
      for (int c = 0; c < vt[i].n; c++) step_cycle($sformatf("row%0d_model", i));
      check($sformatf("row%0d", i), vt[i].duty, vt[i].eo, vt[i].busy, vt[i].done);
    end

    // asynchronous reset mid-ramp at duty 0x50
    en_pwm_in = 16'hFFFF; target_duty = 8'h80; ramp_step = 5'd16; ramp_div = 16'd0;
    for (int c = 0; c < 4; c++) step_cycle("pre_rst");
    check("pre_rst_50", 8'h50, 16'hFFFF, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1 check("async_rst", 8'h00, 16'h0000, 1'b0, 1'b0);
    model_reset();
    master_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_held", 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step_cycle("post_rst_off");
    check("post_rst_idle", 8'h00, 16'h0000, 1'b0, 1'b0);
    master_en = 1'b1;
    step_cycle("post_rst_en");
    check("post_rst_start", 8'h00, 16'hFFFF, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) master_en   = ~master_en;
      if ($urandom_range(0, 14) == 0) target_duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 24) == 0) ramp_div    = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 9)  == 0) ramp_step   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) en_pwm_in   = 16'($urandom);
      step_cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
